// File: rtl/instr_fetch_decode.sv
// -----------------------------------------------------------------------------
// instr_fetch_decode
//
// Sequential fetch/decode front end for a 32-entry instruction memory.
// The block walks PC through the memory, captures each returned word into an
// instruction register (IR) and presents the IR split into a 2-bit opcode and
// six 5-bit fields. A valid/stall handshake throttles issue, and the HALT
// opcode (2'b11) stops fetching until the next start.
//
// Ports:
//   clk           single clock, all state changes on the rising edge
//   rst_n         asynchronous, active-low reset
//   start         begin execution at PC 0 (honoured in IDLE and DONE only)
//   PC     [AW]   fetch address to the instruction memory
//   instr  [m]    memory read data, combinational function of PC
//   stall         downstream not ready, only meaningful while valid = 1
//   valid         decoded outputs hold a real instruction
//   opcode [2]    IR[31:30]
//   fld0..fld5    IR[29:25], IR[24:20], IR[19:15], IR[14:10], IR[9:5], IR[4:0]
//   wrap          one-cycle pulse when PC rolls from 2^AW-1 to 0
//   done          HALT reached, held until restart
//   icount [8]    instructions issued since start, saturating at 255
// -----------------------------------------------------------------------------
module instr_fetch_decode #(
  parameter int m  = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] PC,
  input  logic [m-1:0]  instr,
  input  logic          stall,
  output logic          valid,
  output logic [1:0]    opcode,
  output logic [4:0]    fld0,
  output logic [4:0]    fld1,
  output logic [4:0]    fld2,
  output logic [4:0]    fld3,
  output logic [4:0]    fld4,
  output logic [4:0]    fld5,
  output logic          wrap,
  output logic          done,
  output logic [7:0]    icount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0]    OP_HALT = 2'b11;
  localparam logic [AW-1:0] PC_LAST = {AW{1'b1}};

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [m-1:0]  ir_q, ir_d;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;
  logic [7:0]    icount_q, icount_d;

  // The block may take a new word whenever nothing is being presented
  // downstream, or the downstream stage is accepting the current one.
  logic advance;
  assign advance = !valid_q || !stall;

  // State register: every piece of architectural state lives here and is
  // cleared immediately when rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      icount_q <= icount_d;
    end
  end

  // Next-state logic. Everything holds by default; wrap defaults low so it
  // can only ever be a single-cycle pulse.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    valid_d  = valid_q;
    wrap_d   = 1'b0;
    icount_d = icount_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (advance) begin
          if (instr[m-1:m-2] == OP_HALT) begin
            // HALT is never presented downstream and is not counted; PC
            // stays pointing at the HALT word.
            valid_d = 1'b0;
            state_d = S_DONE;
          end else begin
            ir_d    = instr;
            valid_d = 1'b1;
            pc_d    = pc_q + AW'(1);
            wrap_d  = (pc_q == PC_LAST);
            if (icount_q != 8'hFF) begin
              icount_d = icount_q + 8'd1;
            end
          end
        end
      end

      S_DONE: begin
        // A restart takes priority over anything else; stall is irrelevant
        // here because valid is already low.
        if (start) begin
          pc_d     = '0;
          icount_d = '0;
          valid_d  = 1'b0;
          state_d  = S_RUN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign PC     = pc_q;
  assign valid  = valid_q;
  assign wrap   = wrap_q;
  assign done   = (state_q == S_DONE);
  assign icount = icount_q;

  // The decode is a pure slice of IR; downstream must ignore it while
  // valid is low.
  assign opcode = ir_q[31:30];
  assign fld0   = ir_q[29:25];
  assign fld1   = ir_q[24:20];
  assign fld2   = ir_q[19:15];
  assign fld3   = ir_q[14:10];
  assign fld4   = ir_q[9:5];
  assign fld5   = ir_q[4:0];

endmodule

// File: tb/tb_instr_fetch_decode.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_decode
//
// Directed testbench for instr_fetch_decode. A 32-word memory model answers
// PC combinationally. Inputs change and outputs are sampled on the falling
// edge, half a period away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_decode;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  PC;
  logic [31:0] instr;
  logic        stall;
  logic        valid;
  logic [1:0]  opcode;
  logic [4:0]  fld0, fld1, fld2, fld3, fld4, fld5;
  logic        wrap;
  logic        done;
  logic [7:0]  icount;

  logic [31:0] mem [32];

  int checks = 0;
  int errors = 0;

  instr_fetch_decode #(.m(32), .AW(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .PC     (PC),
    .instr  (instr),
    .stall  (stall),
    .valid  (valid),
    .opcode (opcode),
    .fld0   (fld0),
    .fld1   (fld1),
    .fld2   (fld2),
    .fld3   (fld3),
    .fld4   (fld4),
    .fld5   (fld5),
    .wrap   (wrap),
    .done   (done),
    .icount (icount)
  );

  assign instr = mem[PC];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default memory image: opcode 01 with the address in the low bits, so
  // every word is a distinct non-HALT instruction.
  task automatic fill_mem();
    for (int i = 0; i < 32; i++) begin
      mem[i] = 32'h4000_0000 | 32'(i);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Start pulse sampled on one rising edge; returns at the falling edge
  // just after that edge.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    fill_mem();
    do_reset();
    checks++; if (PC !== 5'd0) begin errors++; $display("[TB] FAIL reset_pc: got %0d expected 0", PC); end
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrap: got %0b expected 0", wrap); end
    checks++; if (icount !== 8'd0) begin errors++; $display("[TB] FAIL reset_icount: got %0d expected 0", icount); end
    checks++; if ({opcode, fld0, fld1, fld2, fld3, fld4, fld5} !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_decode: got %h expected 0", {opcode, fld0, fld1, fld2, fld3, fld4, fld5});
    end
    // Without start the block must sit in IDLE.
    repeat (3) @(negedge clk);
    checks++; if (valid !== 1'b0 || PC !== 5'd0) begin
      errors++; $display("[TB] FAIL idle_hold: got valid=%0b pc=%0d expected valid=0 pc=0", valid, PC);
    end
  endtask

  task automatic test_decode();
    mem[0] = 32'h0850_0443;
    mem[1] = 32'h8850_0443;
    pulse_start();
    // One edge after start: in RUN but nothing latched yet.
    checks++; if (valid !== 1'b0 || PC !== 5'd0) begin
      errors++; $display("[TB] FAIL start_latency: got valid=%0b pc=%0d expected valid=0 pc=0", valid, PC);
    end
    @(negedge clk);
    checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL first_valid: got %0b expected 1", valid); end
    checks++; if (opcode !== 2'b00) begin errors++; $display("[TB] FAIL first_opcode: got %0b expected 00", opcode); end
    checks++; if ({fld0, fld1, fld2, fld3, fld4, fld5} !== {5'd4, 5'd5, 5'd0, 5'd1, 5'd2, 5'd3}) begin
      errors++; $display("[TB] FAIL first_fields: got %0d %0d %0d %0d %0d %0d expected 4 5 0 1 2 3",
                         fld0, fld1, fld2, fld3, fld4, fld5);
    end
    checks++; if (PC !== 5'd1 || icount !== 8'd1) begin
      errors++; $display("[TB] FAIL first_pc_count: got pc=%0d icount=%0d expected pc=1 icount=1", PC, icount);
    end
    @(negedge clk);
    checks++; if (opcode !== 2'b10) begin errors++; $display("[TB] FAIL second_opcode: got %0b expected 10", opcode); end
    checks++; if (PC !== 5'd2 || icount !== 8'd2) begin
      errors++; $display("[TB] FAIL second_pc_count: got pc=%0d icount=%0d expected pc=2 icount=2", PC, icount);
    end
  endtask

  // Continues from test_decode: IR = 0x88500443, PC = 2, icount = 2.
  task automatic test_stall();
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (PC !== 5'd2 || icount !== 8'd2 || valid !== 1'b1 ||
                    {opcode, fld0, fld1, fld2, fld3, fld4, fld5} !== 32'h8850_0443) begin
        errors++; $display("[TB] FAIL stall_hold%0d: got pc=%0d icount=%0d valid=%0b ir=%h expected pc=2 icount=2 valid=1 ir=88500443",
                           c, PC, icount, valid, {opcode, fld0, fld1, fld2, fld3, fld4, fld5});
      end
    end
    stall = 1'b0;
    @(negedge clk);
    checks++; if (PC !== 5'd3 || icount !== 8'd3 || {opcode, fld0, fld1, fld2, fld3, fld4, fld5} !== 32'h4000_0002) begin
      errors++; $display("[TB] FAIL stall_release: got pc=%0d icount=%0d ir=%h expected pc=3 icount=3 ir=40000002",
                         PC, icount, {opcode, fld0, fld1, fld2, fld3, fld4, fld5});
    end
  endtask

  // Continues from test_stall: PC = 3, icount = 3.
  task automatic test_halt();
    mem[5] = 32'hC850_0443;
    @(negedge clk);
    @(negedge clk);
    checks++; if (PC !== 5'd5 || icount !== 8'd5 || valid !== 1'b1) begin
      errors++; $display("[TB] FAIL pre_halt: got pc=%0d icount=%0d valid=%0b expected pc=5 icount=5 valid=1", PC, icount, valid);
    end
    @(negedge clk);
    checks++; if (valid !== 1'b0 || done !== 1'b1 || PC !== 5'd5 || icount !== 8'd5) begin
      errors++; $display("[TB] FAIL halt: got valid=%0b done=%0b pc=%0d icount=%0d expected valid=0 done=1 pc=5 icount=5",
                         valid, done, PC, icount);
    end
    // IR is left holding the last real instruction (Mem[4]).
    checks++; if ({opcode, fld0, fld1, fld2, fld3, fld4, fld5} !== 32'h4000_0004) begin
      errors++; $display("[TB] FAIL halt_ir: got %h expected 40000004", {opcode, fld0, fld1, fld2, fld3, fld4, fld5});
    end
    repeat (2) @(negedge clk);
    checks++; if (done !== 1'b1 || PC !== 5'd5) begin
      errors++; $display("[TB] FAIL done_hold: got done=%0b pc=%0d expected done=1 pc=5", done, PC);
    end
    // Restart with stall also raised: start must win.
    start = 1'b1;
    stall = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stall = 1'b0;
    checks++; if (PC !== 5'd0 || done !== 1'b0 || icount !== 8'd0 || valid !== 1'b0) begin
      errors++; $display("[TB] FAIL restart: got pc=%0d done=%0b icount=%0d valid=%0b expected pc=0 done=0 icount=0 valid=0",
                         PC, done, icount, valid);
    end
    @(negedge clk);
    checks++; if (valid !== 1'b1 || {opcode, fld0, fld1, fld2, fld3, fld4, fld5} !== 32'h0850_0443 || icount !== 8'd1) begin
      errors++; $display("[TB] FAIL restart_issue: got valid=%0b ir=%h icount=%0d expected valid=1 ir=08500443 icount=1",
                         valid, {opcode, fld0, fld1, fld2, fld3, fld4, fld5}, icount);
    end
  endtask

  // Fresh run with no HALT anywhere, followed directly by the saturation run.
  task automatic test_wrap_and_saturate();
    int wrap_cnt;
    fill_mem();
    mem[0] = 32'h0850_0443;
    do_reset();
    pulse_start();
    wrap_cnt = 0;
    for (int n = 1; n <= 33; n++) begin
      @(negedge clk);
      if (wrap === 1'b1) wrap_cnt++;
      if (n == 31) begin
        checks++; if (wrap !== 1'b0 || PC !== 5'd31) begin
          errors++; $display("[TB] FAIL pre_wrap: got wrap=%0b pc=%0d expected wrap=0 pc=31", wrap, PC);
        end
      end
      if (n == 32) begin
        checks++; if (wrap !== 1'b1 || PC !== 5'd0) begin
          errors++; $display("[TB] FAIL wrap: got wrap=%0b pc=%0d expected wrap=1 pc=0", wrap, PC);
        end
      end
      if (n == 33) begin
        checks++; if (wrap !== 1'b0 || icount !== 8'd33 || PC !== 5'd1 ||
                      {opcode, fld0, fld1, fld2, fld3, fld4, fld5} !== 32'h0850_0443) begin
          errors++; $display("[TB] FAIL post_wrap: got wrap=%0b icount=%0d pc=%0d ir=%h expected wrap=0 icount=33 pc=1 ir=08500443",
                             wrap, icount, PC, {opcode, fld0, fld1, fld2, fld3, fld4, fld5});
        end
      end
    end
    checks++; if (wrap_cnt != 1) begin
      errors++; $display("[TB] FAIL wrap_count: got %0d expected 1", wrap_cnt);
    end

    for (int n = 34; n <= 300; n++) begin
      @(negedge clk);
      start = (n == 100);
      if (n == 101) begin
        checks++; if (PC !== 5'd5 || icount !== 8'd101 || valid !== 1'b1) begin
          errors++; $display("[TB] FAIL start_in_run: got pc=%0d icount=%0d valid=%0b expected pc=5 icount=101 valid=1",
                             PC, icount, valid);
        end
      end
      if (n == 254) begin
        checks++; if (icount !== 8'd254) begin errors++; $display("[TB] FAIL count_254: got %0d expected 254", icount); end
      end
      if (n == 256) begin
        checks++; if (icount !== 8'd255) begin errors++; $display("[TB] FAIL count_sat: got %0d expected 255", icount); end
      end
    end
    start = 1'b0;
    checks++; if (icount !== 8'd255 || PC !== 5'd12 || valid !== 1'b1) begin
      errors++; $display("[TB] FAIL count_300: got icount=%0d pc=%0d valid=%0b expected icount=255 pc=12 valid=1", icount, PC, valid);
    end
  endtask

  task automatic test_async_reset();
    fill_mem();
    do_reset();
    pulse_start();
    repeat (7) @(negedge clk);
    checks++; if (PC !== 5'd7 || valid !== 1'b1) begin
      errors++; $display("[TB] FAIL pre_async: got pc=%0d valid=%0b expected pc=7 valid=1", PC, valid);
    end
    // Drop reset between edges and look before the next rising edge.
    #2 rst_n = 1'b0;
    #1;
    checks++; if (PC !== 5'd0 || valid !== 1'b0 || icount !== 8'd0 || done !== 1'b0 || wrap !== 1'b0 ||
                  {opcode, fld0, fld1, fld2, fld3, fld4, fld5} !== 32'h0) begin
      errors++; $display("[TB] FAIL async_reset: got pc=%0d valid=%0b icount=%0d done=%0b wrap=%0b ir=%h expected all 0",
                         PC, valid, icount, done, wrap, {opcode, fld0, fld1, fld2, fld3, fld4, fld5});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (PC !== 5'd0 || valid !== 1'b0 || icount !== 8'd0) begin
      errors++; $display("[TB] FAIL post_reset_idle: got pc=%0d valid=%0b icount=%0d expected 0 0 0", PC, valid, icount);
    end
    pulse_start();
    @(negedge clk);
    checks++; if (valid !== 1'b1 || PC !== 5'd1 || {opcode, fld0, fld1, fld2, fld3, fld4, fld5} !== 32'h4000_0000) begin
      errors++; $display("[TB] FAIL post_reset_run: got valid=%0b pc=%0d ir=%h expected valid=1 pc=1 ir=40000000",
                         valid, PC, {opcode, fld0, fld1, fld2, fld3, fld4, fld5});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    test_reset();
    test_decode();
    test_stall();
    test_halt();
    test_wrap_and_saturate();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Sequential fetch/decode front end that reads the 32-entry instruction memory. It drives the 5-bit `PC` address, captures the returned word into an instruction register, and splits it into opcode and six 5-bit fields for the execute stage. It uses a valid/stall handshake and stops on a HALT opcode. It sits between the instruction `memory` (asynchronous read, indexed by `PC`) and the datapath.

## Interface

Parameters:
- `m`, 32, instruction width; field layout below requires m = 32.
- `AW`, 5, PC width; memory depth is 2^AW.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert and active-low.
- `start`  in  1  begin execution at PC 0. Honoured in IDLE and DONE, ignored in RUN.
- `PC`  out  AW  fetch address to the memory.
- `instr`  in  m  memory read data, combinational function of `PC`.
- `stall`  in  1  downstream not ready. Meaningful only while `valid` = 1.
- `valid`  out  1  decoded outputs hold a real instruction.
- `opcode`  out  2  IR[31:30]
- `fld0`..`fld5`  out  5 each  IR[29:25], IR[24:20], IR[19:15], IR[14:10], IR[9:5], IR[4:0]
- `wrap`  out  1  one-cycle pulse when PC rolls from 2^AW-1 to 0.
- `done`  out  1  HALT reached; held until restart.
- `icount`  out  8  instructions issued since start; saturates at 255.

## Operation

- Opcode 2'b11 is HALT. Opcodes 00, 01 and 10 are ordinary instructions and are passed through undecoded.
- There are three states:
  - IDLE: `PC` = 0, `valid` = 0, `done` = 0. `start` = 1 moves to RUN; PC stays 0.
  - RUN: defined by the advance and hold rules below.
  - DONE: `done` = 1, `valid` = 0, `PC` frozen at the HALT address. `start` = 1 clears `PC`, `icount` and `done`, then moves to RUN.
- In RUN, the block advances when `valid` = 0 or `stall` = 0.
  - Non-HALT word: IR <= `instr`, `valid` <= 1, `PC` <= `PC`+1 modulo 2^AW, `icount` <= `icount`+1 (saturating).
  - HALT word: IR unchanged, `valid` <= 0, `done` <= 1, move to DONE. HALT is never presented with `valid` = 1 and is not counted.
- In RUN with `valid` = 1 and `stall` = 1: IR, `PC`, `icount` and `valid` all hold.
- Wrap-around: the advance from `PC` = 31 sets `PC` = 0 and pulses `wrap` for exactly one cycle. Execution continues; there is no implicit stop.
- The decode fields are always combinational slices of IR. The downstream stage must ignore them while `valid` = 0.
- Reset values, applied to all outputs including mid-operation: state IDLE, `PC` = 0, IR = 0, hence `opcode` and `fld0`..`fld5` = 0; `valid` = 0, `wrap` = 0, `done` = 0, `icount` = 0.

## Timing

- `start` sampled high at edge k moves to RUN at k.
- Mem[0] is latched at edge k+1, so `valid` = 1 after k+1. Latency from start to first valid is 2 edges.
- Throughput is one instruction per cycle when `stall` = 0.
- A `stall` raised in a cycle freezes the outputs at the next edge. Dropping `stall` lets the next word issue at the following edge.
- `start` and `stall` in the same cycle in DONE: `start` wins.
- `rst_n` low takes effect immediately, without waiting for a clock edge. Deassertion is synchronous to the design; the first transition happens at the first edge after release.

## Test plan

- Reset, then `start` pulse, memory Mem[0] = 0x08500443, Mem[1] = 0x88500443 -> two edges after start: `valid` = 1, `opcode` = 00, `fld0`..`fld5` = 4, 5, 0, 1, 2, 3. Next cycle: `opcode` = 10, `PC` = 2, `icount` = 2.
- Hold `stall` = 1 for 3 cycles while `valid` = 1 -> `PC`, IR and `icount` unchanged across all 3 cycles. One new instruction issues on the edge after `stall` falls.
- Mem[5] = 0xC8500443 (HALT) -> after Mem[4] issues: `valid` = 0, `done` = 1, `PC` = 5, `icount` = 5. A later `start` gives `PC` = 0, `done` = 0, `icount` = 0, and Mem[0] is re-issued.
- No HALT in memory, run 33 advances -> `wrap` is high for exactly one cycle when `PC` goes 31 -> 0, then Mem[0] issues again with `icount` = 33.
- Run long enough for 300 issues with `start` pulsed mid-RUN -> `start` ignored in RUN, and `icount` saturates at 255.
- Assert `rst_n` = 0 between edges while `valid` = 1 and `PC` = 7 -> outputs go to reset values immediately. After release, the block stays in IDLE until `start`.
